fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, PC value loaded on reset.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 ihit  in  1  instruction memory returns valid word on iload this cycle.
REQ-005 iload  in  32  instruction word from instruction memory.
REQ-006 iREN  out  1  instruction read request.
REQ-007 iaddr  out  32  instruction address, equal to current PC.
REQ-008 stall  in  1  hazard stall; hold IF/ID contents and PC.
REQ-009 flush  in  1  squash IF/ID contents.
REQ-010 redirect  in  1  load redirect_pc into PC (taken branch, jump, jr).
REQ-011 redirect_pc  in  32  target address.
REQ-012 instr  out  32  IF/ID instruction, feeds control unit opcode/funct decode.
REQ-013 npc  out  32  PC+4 of the instruction held in instr.
REQ-014 valid  out  1  instr holds a real fetched instruction.
REQ-015 halted  out  1  fetch frozen on HALT (tied 0 when FETCH_HALT_DETECT_EN undefined).

Function
REQ-016 FSM states FETCH, HOLD, HALTED; iaddr = PC combinationally in every state.
REQ-017 iREN = 1 only in FETCH with stall = 0; 0 in HOLD and HALTED.
REQ-018 Per-cycle priority: RST > redirect > flush > stall > ihit.
REQ-019 redirect: PC <= redirect_pc, instr <= 0, npc <= 0, valid <= 0, skid buffer cleared, state <= FETCH; same-cycle ihit discarded.
REQ-020 flush without redirect: instr <= 0, npc <= 0, valid <= 0, skid buffer cleared, state <= FETCH; PC unchanged; same-cycle ihit discarded.
REQ-021 FETCH, ihit, stall = 0: instr <= iload, npc <= PC+4, valid <= 1, PC <= PC+4.
REQ-022 FETCH, ihit = 0, stall = 0: bubble inserted -- instr <= 0, npc <= 0, valid <= 0; PC held.
REQ-023 FETCH, stall = 1, ihit = 0: IF/ID and PC held.
REQ-024 FETCH, stall = 1, ihit = 1 (request issued earlier and completing late): iload and PC+4 captured in one-entry skid buffer, PC <= PC+4, IF/ID held, state <= HOLD.
REQ-025 HOLD, stall = 1: everything held; HOLD, stall = 0: IF/ID <= skid buffer, valid <= 1, state <= FETCH.
REQ-026 PC+4 wraps modulo 2^32: 32'hFFFFFFFC -> 32'h00000000, no flag.
REQ-027 PC bits [1:0] forced 0 on every load, including redirect_pc.

Reset
REQ-028 RST = 1 at clock edge: PC <= PC_INIT, instr <= 0, npc <= 0, valid <= 0, halted <= 0, skid buffer empty, state <= FETCH; overrides any in-flight ihit, stall, flush, redirect.
REQ-029 While RST held high, iREN = 0; first request issued cycle after RST deasserts.

Configuration
REQ-030 Macro FETCH_HALT_DETECT_EN defined: when a word with opcode 6'h3F (HALT) is latched into IF/ID, state <= HALTED, halted <= 1, PC frozen, iREN = 0.
REQ-031 In HALTED, redirect or flush returns to FETCH per REQ-019/020 and clears halted (squashed HALT); only these or RST exit.
REQ-032 Macro undefined: HALT opcode passed as ordinary instruction, no HALTED state, halted tied 0.

Verification
REQ-033 RST 2 cycles, PC_INIT=0, ihit=1 each cycle, iload=32'h20010001,32'h20020002 -> iaddr 0,4,8; instr/npc = 32'h20010001/4 then 32'h20020002/8; valid=1.
REQ-034 ihit=0 for 3 cycles at PC=0x10 -> iaddr stays 0x10, valid=0, instr=0 for 3 cycles, iREN=1.
REQ-035 stall=1 with ihit=1, iload=32'h8C220000 at PC=0x20 -> state HOLD, iREN=0, PC=0x24, IF/ID unchanged; stall drops -> instr=32'h8C220000, npc=0x24, valid=1.
REQ-036 redirect=1, redirect_pc=32'h00000103, ihit=1, flush=1 same cycle -> PC=0x100, valid=0, instr=0, next iaddr=0x100.
REQ-037 PC=32'hFFFFFFFC, ihit=1 -> npc=0, next iaddr=0.
REQ-038 Macro defined, iload=32'hFC000000 -> halted=1, iREN=0 next cycle, PC frozen; flush=1 -> halted=0, iREN=1; macro undefined -> halted stays 0, fetch continues.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction reads and loads the IF/ID register.
// Latency: a word returned with ihit reaches instr/npc/valid on the next rising edge (one extra cycle if it lands in the skid buffer).
// Backpressure: stall holds PC and IF/ID; a late ihit under stall parks in a one-entry skid buffer. Optional HALT detect: FETCH_HALT_DETECT_EN.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] npc,
   output logic        valid,
   output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALTED = 2'd2} state_t;
`else
   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_npc_q, skid_npc_d;
   logic        halted_q, halted_d;
   logic [31:0] pc_plus4;

   // Sequential increment; wraps naturally at the top of the address space.
   assign pc_plus4 = (pc_q + 32'd4) & WORD_MASK;

   // Reads go out only while actively fetching; reset masks the request.
   assign iREN   = !RST && (state_q == FETCH) && !stall;
   assign iaddr  = pc_q;
   assign instr  = instr_q;
   assign npc    = npc_q;
   assign valid  = valid_q;
`ifdef FETCH_HALT_DETECT_EN
   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   // Next-state logic; priority is redirect, then flush, then stall, then ihit.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      npc_d        = npc_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_npc_d   = skid_npc_q;
      halted_d     = halted_q;

      if (redirect || flush) begin
         // Squash IF/ID and the skid buffer; a squashed HALT also unfreezes fetch.
         if (redirect) begin
            pc_d = redirect_pc & WORD_MASK;
         end
         instr_d      = 32'h0;
         npc_d        = 32'h0;
         valid_d      = 1'b0;
         skid_instr_d = 32'h0;
         skid_npc_d   = 32'h0;
         halted_d     = 1'b0;
         state_d      = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (stall) begin
                  if (ihit) begin
                     // Late return under stall: park it, advance PC, leave IF/ID alone.
                     skid_instr_d = iload;
                     skid_npc_d   = pc_plus4;
                     pc_d         = pc_plus4;
                     state_d      = HOLD;
                  end
               end else if (ihit) begin
                  instr_d = iload;
                  npc_d   = pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4;
`ifdef FETCH_HALT_DETECT_EN
                  if (iload[31:26] == 6'h3F) begin
                     state_d  = HALTED;
                     halted_d = 1'b1;
                  end
`endif
               end else begin
                  // Memory not ready: insert a bubble, retry the same PC.
                  instr_d = 32'h0;
                  npc_d   = 32'h0;
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_d      = skid_instr_q;
                  npc_d        = skid_npc_q;
                  valid_d      = 1'b1;
                  skid_instr_d = 32'h0;
                  skid_npc_d   = 32'h0;
                  state_d      = FETCH;
`ifdef FETCH_HALT_DETECT_EN
                  if (skid_instr_q[31:26] == 6'h3F) begin
                     state_d  = HALTED;
                     halted_d = 1'b1;
                  end
`endif
               end
            end
            default: begin
               // HALTED: frozen until redirect, flush or reset.
            end
         endcase
      end
   end

   // State registers with synchronous reset overriding everything else.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= FETCH;
         pc_q         <= PC_INIT & WORD_MASK;
         instr_q      <= 32'h0;
         npc_q        <= 32'h0;
         valid_q      <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_npc_q   <= 32'h0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         npc_q        <= npc_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_npc_q   <= skid_npc_d;
         halted_q     <= halted_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, bubbles, skid buffer,
// redirect/flush priority, PC wrap and HALT handling (both macro settings).
// Inputs change 1 ns after the rising edge; outputs are sampled there as well.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] iload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] npc;
   logic        valid;
   logic        halted;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.PC_INIT(32'h00000000)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr(instr), .npc(npc), .valid(valid), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; ihit = 1'b1; iload = 32'h20010001; stall = 1'b0;
      flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      #1;
      checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iren_early got %b exp 0", iREN); end
      tick();
      tick();
      checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iren_held got %b exp 0", iREN); end
      checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %h exp 00000000", iaddr); end
      checks++; if (instr !== 32'h0 || npc !== 32'h0) begin errors++; $display("FAIL rst_ifid got %h/%h exp 0/0", instr, npc); end
      checks++; if (valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_flags got v%b h%b exp v0 h0", valid, halted); end
      RST = 1'b0;
      #1;
      checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rst_iren_release got %b exp 1", iREN); end
   endtask

   task automatic test_sequential();
      tick();
      checks++; if (instr !== 32'h20010001 || npc !== 32'h4 || valid !== 1'b1) begin errors++; $display("FAIL seq_first got %h/%h/%b exp 20010001/00000004/1", instr, npc, valid); end
      checks++; if (iaddr !== 32'h4) begin errors++; $display("FAIL seq_iaddr1 got %h exp 00000004", iaddr); end
      iload = 32'h20020002;
      tick();
      checks++; if (instr !== 32'h20020002 || npc !== 32'h8 || valid !== 1'b1) begin errors++; $display("FAIL seq_second got %h/%h/%b exp 20020002/00000008/1", instr, npc, valid); end
      checks++; if (iaddr !== 32'h8) begin errors++; $display("FAIL seq_iaddr2 got %h exp 00000008", iaddr); end
   endtask

   task automatic test_bubble();
      ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
      tick();
      redirect = 1'b0;
      checks++; if (iaddr !== 32'h10) begin errors++; $display("FAIL bub_redirect got %h exp 00000010", iaddr); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (iaddr !== 32'h10 || valid !== 1'b0 || instr !== 32'h0 || iREN !== 1'b1) begin
            errors++; $display("FAIL bub_cycle%0d got a=%h v=%b i=%h r=%b exp a=00000010 v=0 i=0 r=1", i, iaddr, valid, instr, iREN);
         end
      end
   endtask

   task automatic test_skid();
      redirect = 1'b1; redirect_pc = 32'h1C;
      tick();
      redirect = 1'b0; ihit = 1'b1; iload = 32'hAAAA5555;
      tick();
      checks++; if (instr !== 32'hAAAA5555 || npc !== 32'h20 || iaddr !== 32'h20) begin errors++; $display("FAIL skid_pre got %h/%h/%h exp aaaa5555/00000020/00000020", instr, npc, iaddr); end
      stall = 1'b1; iload = 32'h8C220000;
      tick();
      checks++; if (iREN !== 1'b0 || iaddr !== 32'h24) begin errors++; $display("FAIL skid_hold got r=%b a=%h exp r=0 a=00000024", iREN, iaddr); end
      checks++; if (instr !== 32'hAAAA5555 || npc !== 32'h20 || valid !== 1'b1) begin errors++; $display("FAIL skid_ifid_held got %h/%h/%b exp aaaa5555/00000020/1", instr, npc, valid); end
      ihit = 1'b0; iload = 32'h0;
      tick();
      checks++; if (instr !== 32'hAAAA5555 || iaddr !== 32'h24) begin errors++; $display("FAIL skid_hold2 got %h/%h exp aaaa5555/00000024", instr, iaddr); end
      stall = 1'b0;
      #1;
      checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL skid_hold_iren got %b exp 0", iREN); end
      tick();
      checks++; if (instr !== 32'h8C220000 || npc !== 32'h24 || valid !== 1'b1) begin errors++; $display("FAIL skid_release got %h/%h/%b exp 8c220000/00000024/1", instr, npc, valid); end
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h24) begin errors++; $display("FAIL skid_resume got r=%b a=%h exp r=1 a=00000024", iREN, iaddr); end
   endtask

   task automatic test_redirect_flush();
      ihit = 1'b1; iload = 32'hDEADBEEF; redirect = 1'b1; flush = 1'b1; redirect_pc = 32'h00000103;
      tick();
      redirect = 1'b0; flush = 1'b0; iload = 32'h12345678;
      checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp 00000100", iaddr); end
      checks++; if (valid !== 1'b0 || instr !== 32'h0 || npc !== 32'h0) begin errors++; $display("FAIL redir_squash got %b/%h/%h exp 0/0/0", valid, instr, npc); end
      tick();
      checks++; if (instr !== 32'h12345678 || npc !== 32'h104 || iaddr !== 32'h104) begin errors++; $display("FAIL redir_fetch got %h/%h/%h exp 12345678/00000104/00000104", instr, npc, iaddr); end
      flush = 1'b1; iload = 32'h0BADF00D;
      tick();
      flush = 1'b0;
      checks++; if (iaddr !== 32'h104 || valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL flush_only got a=%h v=%b i=%h exp a=00000104 v=0 i=0", iaddr, valid, instr); end
   endtask

   task automatic test_wrap();
      ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      tick();
      redirect = 1'b0; ihit = 1'b1; iload = 32'h00000020;
      checks++; if (iaddr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", iaddr); end
      tick();
      checks++; if (npc !== 32'h0 || iaddr !== 32'h0 || instr !== 32'h00000020) begin errors++; $display("FAIL wrap got n=%h a=%h i=%h exp n=0 a=0 i=00000020", npc, iaddr, instr); end
   endtask

   task automatic test_halt();
      iload = 32'hFC000000;
      tick();
`ifdef FETCH_HALT_DETECT_EN
      checks++; if (halted !== 1'b1 || iREN !== 1'b0) begin errors++; $display("FAIL halt_enter got h=%b r=%b exp h=1 r=0", halted, iREN); end
      iload = 32'h20030003;
      tick();
      checks++; if (iaddr !== 32'h4 || instr !== 32'hFC000000) begin errors++; $display("FAIL halt_frozen got a=%h i=%h exp a=00000004 i=fc000000", iaddr, instr); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (halted !== 1'b0 || iREN !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL halt_exit got h=%b r=%b v=%b exp h=0 r=1 v=0", halted, iREN, valid); end
`else
      checks++; if (halted !== 1'b0 || iREN !== 1'b1 || instr !== 32'hFC000000) begin errors++; $display("FAIL halt_plain got h=%b r=%b i=%h exp h=0 r=1 i=fc000000", halted, iREN, instr); end
      iload = 32'h20030003;
      tick();
      checks++; if (iaddr !== 32'h8 || instr !== 32'h20030003 || halted !== 1'b0) begin errors++; $display("FAIL halt_continue got a=%h i=%h h=%b exp a=00000008 i=20030003 h=0", iaddr, instr, halted); end
`endif
   endtask

   task automatic test_reset_override();
      RST = 1'b1; ihit = 1'b1; stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000400;
      tick();
      checks++; if (iaddr !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL rst_override got a=%h v=%b i=%h h=%b exp a=0 v=0 i=0 h=0", iaddr, valid, instr, halted); end
      checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_override_iren got %b exp 0", iREN); end
      RST = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; ihit = 1'b0;
      tick();
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h0) begin errors++; $display("FAIL rst_override_resume got r=%b a=%h exp r=1 a=0", iREN, iaddr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_bubble();
      test_skid();
      test_redirect_flush();
      test_wrap();
      test_halt();
      test_reset_override();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
